// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory, and feeds decode
// through a 2-entry buffer with valid/ready handshake and redirect flush.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] readAddress,
   input  logic [31:0] instruction,
   input  logic        fetchEnable,
   input  logic        redirectValid,
   input  logic [31:0] redirectTarget,
   output logic        instrValid,
   input  logic        instrReady,
   output logic [31:0] instrOut,
   output logic [31:0] instrPc
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } entry_t;

   entry_t      fifo [2];
   logic [31:0] fetch_pc;
   logic [1:0]  count;
   logic        rd_ptr;
   logic        wr_ptr;
   logic        pop;
   logic        capture;

   assign instrValid  = (count != 2'd0);
   assign pop         = instrValid & instrReady;
   assign capture     = fetchEnable & ~redirectValid
                      & ((count != 2'd2) | pop);
   assign readAddress = fetch_pc;
   assign instrOut    = fifo[rd_ptr].word;
   assign instrPc     = fifo[rd_ptr].pc;

   // Redirect wins: flush pointers and count, restart at aligned target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
      end else if (redirectValid) begin
         fetch_pc <= {redirectTarget[31:2], 2'b00};
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
      end else begin
         if (capture) begin
            fetch_pc <= fetch_pc + 32'd4;
            wr_ptr   <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, capture} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo[0] <= '0;
         fifo[1] <= '0;
      end else if (capture) begin
         fifo[wr_ptr] <= '{pc: fetch_pc, word: instruction};
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-level reference model of the
// fetch buffer, directed scenarios followed by randomized traffic.
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } item_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] readAddress;
   logic [31:0] instruction;
   logic        fetchEnable;
   logic        redirectValid;
   logic [31:0] redirectTarget;
   logic        instrValid;
   logic        instrReady;
   logic [31:0] instrOut;
   logic [31:0] instrPc;

   int n_tests = 0;
   int n_fail  = 0;

   item_t       m_q[$];
   logic [31:0] m_pc = RESET_PC;
   logic        m_pop;
   logic        m_cap;

   instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .readAddress    (readAddress),
      .instruction    (instruction),
      .fetchEnable    (fetchEnable),
      .redirectValid  (redirectValid),
      .redirectTarget (redirectTarget),
      .instrValid     (instrValid),
      .instrReady     (instrReady),
      .instrOut       (instrOut),
      .instrPc        (instrPc)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a < 32'd32) return 32'h2001_0001 + (a >> 2);
      return {a[15:0], ~a[31:16]};
   endfunction

   assign instruction = mem(readAddress);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the buffer as a FIFO queue of {pc, word}.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_pc = RESET_PC;
      end else begin
         m_pop = (m_q.size() != 0) && instrReady;
         if (redirectValid) begin
            m_q.delete();
            m_pc = redirectTarget & 32'hFFFF_FFFC;
         end else begin
            m_cap = fetchEnable && ((m_q.size() < 2) || m_pop);
            if (m_pop) void'(m_q.pop_front());
            if (m_cap) begin
               m_q.push_back('{m_pc, mem(m_pc)});
               m_pc = m_pc + 32'd4;
            end
         end
      end
   end

   // Monitor: compare DUT outputs against the model away from the edge.
   always @(negedge clk) begin
      chk("read_address", readAddress, m_pc);
      chk("instr_valid", {31'd0, instrValid}, {31'd0, m_q.size() != 0});
      if (instrValid && m_q.size() != 0) begin
         chk("head_pc", instrPc, m_q[0].pc);
         chk("head_word", instrOut, m_q[0].word);
      end
   end

   task automatic step(input logic en, input logic rv,
                       input logic [31:0] tg, input logic rdy);
      fetchEnable    = en;
      redirectValid  = rv;
      redirectTarget = tg;
      instrReady     = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n          = 1'b0;
      fetchEnable    = 1'b0;
      redirectValid  = 1'b0;
      redirectTarget = '0;
      instrReady     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, instrValid}, 32'd0);
      chk("rst_addr", readAddress, RESET_PC);
      chk("rst_out", instrOut, 32'd0);
      chk("rst_pc", instrPc, 32'd0);

      // Stream
      rst_n = 1'b1;
      step(1, 0, 0, 1);
      chk("first_pc", instrPc, 32'd0);
      chk("first_word", instrOut, 32'h2001_0001);
      repeat (6) step(1, 0, 0, 1);

      // Back-pressure then release
      repeat (5) step(1, 0, 0, 0);
      repeat (4) step(1, 0, 0, 1);

      // Redirect with a full buffer
      repeat (2) step(1, 0, 0, 0);
      step(1, 1, 32'h0000_0013, 1);
      chk("redir_addr", readAddress, 32'h0000_0010);
      chk("redir_valid", {31'd0, instrValid}, 32'd0);
      step(1, 0, 0, 1);
      chk("redir_pc", instrPc, 32'h0000_0010);

      // Fetch gating
      repeat (3) step(0, 0, 0, 1);
      chk("gate_valid", {31'd0, instrValid}, 32'd0);
      repeat (3) step(1, 0, 0, 1);

      // Wrap-around
      step(1, 1, 32'hFFFF_FFFC, 1);
      step(1, 0, 0, 1);
      chk("wrap_pc0", instrPc, 32'hFFFF_FFFC);
      step(1, 0, 0, 1);
      chk("wrap_pc1", instrPc, 32'h0000_0000);

      // Async reset mid-stream with a full buffer
      repeat (3) step(1, 0, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, instrValid}, 32'd0);
      chk("arst_addr", readAddress, RESET_PC);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1, 0, 0, 1);
      chk("arst_restart", instrPc, RESET_PC);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] tg;
         tg = ($urandom_range(0, 1) == 0) ? $urandom()
                                          : 32'hFFFF_FFF0 | $urandom_range(0, 15);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              tg, $urandom_range(0, 2) != 0);
      end
      step(0, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Requester-side counterpart of the instruction memory: holds the program counter, drives `readAddress` into the combinational instruction memory, captures the returned `instruction` into a 2-entry fetch buffer, and presents fetched words to decode over a valid/ready handshake. Sits between the instruction memory and the decode stage of the MIPS datapath. Supports decode back-pressure, fetch gating, and branch/jump redirects that flush the buffer.

## Interface
- `RESET_PC`, 32'h0000_0000, byte address of the first fetched instruction; bits [1:0] must be 0.
- `clk`  input  1  rising-edge clock, single clock domain.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `readAddress`  output  32  byte address to instruction memory; equals `fetchPc`.
- `instruction`  input  32  memory read data; combinational function of `readAddress`, valid in the same cycle.
- `fetchEnable`  input  1  1 = capture and advance allowed this cycle.
- `redirectValid`  input  1  1-cycle pulse: flush and restart fetch at `redirectTarget`.
- `redirectTarget`  input  32  new PC; bits [1:0] forced to 0 internally.
- `instrValid`  output  1  buffer head holds a valid instruction.
- `instrReady`  input  1  decode accepts the head this cycle.
- `instrOut`  output  32  instruction word at buffer head.
- `instrPc`  output  32  byte address of `instrOut`.

## Operation
- State: `fetchPc` (32b), buffer of 2 entries {pc, word}, 2-bit `count` (0..2), 1-bit read/write pointers.
- `pop` = `instrValid & instrReady`.
- `capture` = `fetchEnable & ~redirectValid & (count < 2 | pop)`.
- On `capture`: write {`fetchPc`, `instruction`} at write pointer; `fetchPc <= fetchPc + 4` (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
- On `pop` (no redirect): advance read pointer.
- `count` next = count + capture - pop; never exceeds 2, never below 0.
- Redirect (highest priority): `count <= 0`, pointers <= 0, `fetchPc <= {redirectTarget[31:2], 2'b00}`; same-cycle capture suppressed; same-cycle pop still counts as accepted by decode (head was valid and handshake completed) but buffer is cleared regardless.
- `fetchEnable = 0`: no capture, `fetchPc` holds; pops continue to drain the buffer.
- Outputs: `instrValid = (count != 0)`; `instrOut`/`instrPc` = entry at read pointer (don't-care when `instrValid = 0`, but must be stable while valid & not ready).
- FIFO order strictly preserved; no instruction dropped or duplicated outside of redirect flush.

## Timing
- Reset (async, `rst_n = 0`): `fetchPc = RESET_PC`, `count = 0`, `instrValid = 0`, `instrOut = 0`, `instrPc = 0`, `readAddress = RESET_PC`.
- Reset mid-operation: all state returns to reset values immediately; in-flight buffer contents discarded.
- Fetch latency: word addressed in cycle N appears at head with `instrValid = 1` in cycle N+1 (if buffer was empty).
- Redirect penalty: redirect in cycle N -> `readAddress = target` in N+1 -> `instrValid` with `instrPc = target` in N+2.
- Sustained throughput: 1 instruction/cycle when `instrReady = 1` and `fetchEnable = 1`.
- Full buffer (`count = 2`) with `instrReady = 0`: `fetchPc` holds, `readAddress` stable; with `instrReady = 1` capture and pop occur in the same cycle, `count` stays 2.
- Back-pressure: head outputs hold value while `instrValid & ~instrReady`.

## Test plan
- Reset/stream: memory words 0..7 = 32'h2001_0001+i, `RESET_PC = 0`, `instrReady = 1` -> after `rst_n` rises, cycle 1 `instrPc = 0`, `instrOut = 32'h2001_0001`; then `instrPc` 4, 8, ... one per cycle, no gaps.
- Back-pressure: `instrReady = 0` for 5 cycles after first valid -> `count` saturates at 2, `readAddress` holds at 8, head stays pc 0; release -> pc 0, 4, 8 delivered in order, none lost.
- Redirect: `redirectValid` pulse with target 32'h0000_0013 while buffer holds 2 entries -> next cycle `instrValid = 0`, `readAddress = 32'h10`; following cycle `instrPc = 32'h10`.
- Fetch gating: `fetchEnable = 0` for 3 cycles with `instrReady = 1` -> buffer drains to empty, `instrValid = 0`, `readAddress` constant; re-enable -> resumes at held PC.
- Wrap-around: redirect to 32'hFFFF_FFFC -> delivered pcs FFFF_FFFC then 0000_0000.
- Async reset mid-stream: drop `rst_n` between clock edges with `count = 2` -> `instrValid` falls immediately, `readAddress = RESET_PC`; after release fetch restarts at `RESET_PC`.
